// File: rtl/apb_spi_master_ctrl.sv
// APB3 register front-end driving a single-chip-select, mode-0 SPI master.
// Frame order: command byte, optional 24/32-bit address, then up to 4 data bytes written or read.
module apb_spi_master_ctrl #(
  parameter int         ADDR_WIDTH  = 4,
  parameter logic [7:0] DEFAULT_DIV = 8'd1
) (
  input  logic                  pclk_i,
  input  logic                  rst_n_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic                  pwrite_i,
  input  logic [31:0]           pwdata_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  spi_clk_o,
  output logic                  spi_sdo_o,
  output logic                  spi_cs_n_o,
  input  logic                  spi_sdi_i
);

  localparam logic [ADDR_WIDTH-1:0] IDX_CMD   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] IDX_ADDR  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LEN   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] IDX_WDATA = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] IDX_RDATA = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] IDX_CTRL  = ADDR_WIDTH'(5);

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_TAIL} state_t;

  state_t      state_r;
  logic [7:0]  cmd_r;
  logic [31:0] addr_r;
  logic [2:0]  len_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic        rw_r;
  logic        addr_en_r;
  logic        addr32_r;
  logic [7:0]  clkdiv_r;
  logic [7:0]  hcnt_r;
  logic [6:0]  bits_left_r;
  logic [2:0]  dlen_r;
  logic [70:0] shift_r;
  logic        sclk_r;
  logic        sdo_r;
  logic        cs_n_r;

  logic        busy_s;
  logic        wr_s;
  logic        start_s;
  logic [2:0]  len_eff_s;
  logic [5:0]  abits_s;
  logic [31:0] wd_al_s;
  logic [71:0] addr_part_s;
  logic [71:0] frame_s;
  logic [6:0]  nbits_s;

  assign busy_s     = (state_r != ST_IDLE);
  assign wr_s       = psel_i && penable_i && pwrite_i;
  assign start_s    = wr_s && !busy_s && (paddr_i == IDX_CTRL) && pwdata_i[0];
  assign pready_o   = 1'b1;
  assign spi_clk_o  = sclk_r;
  assign spi_sdo_o  = sdo_r;
  assign spi_cs_n_o = cs_n_r;

  // Assemble the left-aligned frame from the mode bits carried by the launching CTRL write.
  always_comb begin
    len_eff_s   = (len_r > 3'd4) ? 3'd4 : len_r;
    abits_s     = 6'd0;
    addr_part_s = 72'd0;
    if (pwdata_i[2]) begin
      if (pwdata_i[3]) begin
        abits_s     = 6'd32;
        addr_part_s = {8'd0, addr_r, 32'd0};
      end else begin
        abits_s     = 6'd24;
        addr_part_s = {8'd0, addr_r[23:0], 40'd0};
      end
    end else begin
      abits_s     = 6'd0;
      addr_part_s = 72'd0;
    end
    if (pwdata_i[1]) begin
      wd_al_s = 32'd0;
    end else begin
      wd_al_s = wdata_r << (6'd32 - {len_eff_s, 3'b000});
    end
    frame_s = {cmd_r, 64'd0} | addr_part_s | ({40'd0, wd_al_s} << (6'd32 - abits_s));
    nbits_s = 7'd8 + {1'b0, abits_s} + {1'b0, len_eff_s, 3'b000};
  end

  // Register-file writes; everything is frozen while a transfer is in flight.
  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmd_r     <= 8'd0;
      addr_r    <= 32'd0;
      len_r     <= 3'd0;
      wdata_r   <= 32'd0;
      rw_r      <= 1'b0;
      addr_en_r <= 1'b0;
      addr32_r  <= 1'b0;
      clkdiv_r  <= DEFAULT_DIV;
    end else if (wr_s && !busy_s) begin
      case (paddr_i)
        IDX_CMD:   cmd_r   <= pwdata_i[7:0];
        IDX_ADDR:  addr_r  <= pwdata_i;
        IDX_LEN:   len_r   <= pwdata_i[2:0];
        IDX_WDATA: wdata_r <= pwdata_i;
        IDX_CTRL: begin
          rw_r      <= pwdata_i[1];
          addr_en_r <= pwdata_i[2];
          addr32_r  <= pwdata_i[3];
          clkdiv_r  <= pwdata_i[15:8];
        end
        default: cmd_r <= cmd_r;
      endcase
    end else begin
      cmd_r <= cmd_r;
    end
  end

  // SPI sequencer: each phase lasts clkdiv+1 cycles; MISO is captured on rising edges of the data phase.
  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_IDLE;
      rdata_r     <= 32'd0;
      hcnt_r      <= 8'd0;
      bits_left_r <= 7'd0;
      dlen_r      <= 3'd0;
      shift_r     <= 71'd0;
      sclk_r      <= 1'b0;
      sdo_r       <= 1'b0;
      cs_n_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r     <= ST_LOW;
            cs_n_r      <= 1'b0;
            sdo_r       <= frame_s[71];
            shift_r     <= frame_s[70:0];
            bits_left_r <= nbits_s;
            dlen_r      <= len_eff_s;
            hcnt_r      <= 8'd0;
            if (pwdata_i[1]) begin
              rdata_r <= 32'd0;
            end else begin
              rdata_r <= rdata_r;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOW: begin
          if (hcnt_r == clkdiv_r) begin
            hcnt_r  <= 8'd0;
            sclk_r  <= 1'b1;
            state_r <= ST_HIGH;
            if (rw_r && (bits_left_r <= {1'b0, dlen_r, 3'b000})) begin
              rdata_r <= {rdata_r[30:0], spi_sdi_i};
            end else begin
              rdata_r <= rdata_r;
            end
          end else begin
            hcnt_r <= hcnt_r + 8'd1;
          end
        end
        ST_HIGH: begin
          if (hcnt_r == clkdiv_r) begin
            hcnt_r      <= 8'd0;
            sclk_r      <= 1'b0;
            bits_left_r <= bits_left_r - 7'd1;
            shift_r     <= {shift_r[69:0], 1'b0};
            if (bits_left_r == 7'd1) begin
              state_r <= ST_TAIL;
              sdo_r   <= 1'b0;
            end else begin
              state_r <= ST_LOW;
              sdo_r   <= shift_r[70];
            end
          end else begin
            hcnt_r <= hcnt_r + 8'd1;
          end
        end
        ST_TAIL: begin
          if (hcnt_r == clkdiv_r) begin
            hcnt_r  <= 8'd0;
            cs_n_r  <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            hcnt_r <= hcnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          sclk_r  <= 1'b0;
          cs_n_r  <= 1'b1;
        end
      endcase
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    prdata_o = 32'd0;
    if (psel_i && !pwrite_i) begin
      case (paddr_i)
        IDX_CMD:   prdata_o = {24'd0, cmd_r};
        IDX_ADDR:  prdata_o = addr_r;
        IDX_LEN:   prdata_o = {29'd0, len_r};
        IDX_WDATA: prdata_o = wdata_r;
        IDX_RDATA: prdata_o = rdata_r;
        IDX_CTRL:  prdata_o = {16'd0, clkdiv_r, busy_s, 3'b000, addr32_r, addr_en_r, rw_r, 1'b0};
        default:   prdata_o = 32'd0;
      endcase
    end else begin
      prdata_o = 32'd0;
    end
  end

endmodule

// File: tb/tb_apb_spi_master_ctrl.sv
// Scoreboard bench for apb_spi_master_ctrl: APB register traffic plus a pin-level SPI monitor and slave.
module tb_apb_spi_master_ctrl;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, sclk, sdo, cs_n;
  logic        sdi = 1'b0;

  apb_spi_master_ctrl #(.ADDR_WIDTH(4), .DEFAULT_DIV(8'd1)) dut (
    .pclk_i(pclk), .rst_n_i(rst_n), .psel_i(psel), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata),
    .pready_o(pready), .spi_clk_o(sclk), .spi_sdo_o(sdo), .spi_cs_n_o(cs_n),
    .spi_sdi_i(sdi)
  );

  always #5 pclk = ~pclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  bit          exp_bits[$];
  bit          obs_bits[$];
  int          pulses = 0;
  int          cs_cnt = 0;
  bit          seen_low = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic [71:0] slave_bits = 72'd0;
  int          sidx = 0;

  // Pin monitor and mode-0 slave, evaluated on the falling pclk edge.
  always @(negedge pclk) begin
    if (sclk && !prev_sclk) begin
      obs_bits.push_back(sdo);
      pulses++;
    end
    if (!sclk && prev_sclk && sidx < 71) begin
      sidx++;
      sdi = slave_bits[71-sidx];
    end
    if (!cs_n && prev_cs) begin
      sidx = 0;
      sdi  = slave_bits[71];
    end
    if (!cs_n) begin
      cs_cnt++;
      seen_low = 1'b1;
    end
    prev_sclk = sclk;
    prev_cs   = cs_n;
  end

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge pclk); #1;
    penable = 1'b1;
    d = prdata;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic prep_txn();
    obs_bits.delete();
    exp_bits.delete();
    pulses = 0;
    cs_cnt = 0;
    seen_low = 1'b0;
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_bits.push_back(v[i]);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge pclk); #1;
      if (seen_low && cs_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int drain_mismatches();
    int m = 0;
    while (exp_bits.size() > 0 && obs_bits.size() > 0) begin
      if (exp_bits.pop_front() != obs_bits.pop_front()) m++;
    end
    return m + exp_bits.size() + obs_bits.size();
  endfunction

  task automatic test_reset();
    logic [31:0] d, e;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'd0; pwdata = 32'd0;
    repeat (3) @(posedge pclk);
    #1;
    n_checks++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b expected 0", sdo); end
    n_checks++; if (pready !== 1'b1) begin n_fail++; $display("FAIL reset_pready: got %b expected 1", pready); end
    n_checks++; if (prdata !== 32'd0) begin n_fail++; $display("FAIL reset_prdata: got %h expected 0", prdata); end
    @(negedge pclk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back((i == 5) ? 32'h0000_0100 : 32'h0);
    for (int i = 0; i < 8; i++) begin
      apb_read(4'(i), d);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== e) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected %h", i, d, e); end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d, e;
    logic [3:0]  idx[7];
    logic [31:0] wv[7];
    idx = '{4'd1, 4'd0, 4'd2, 4'd3, 4'd4, 4'd6, 4'd5};
    wv  = '{32'habcd1234, 32'h0000_01FF, 32'h0000_0007, 32'h55aa00ff, 32'hffffffff, 32'h12345678, 32'hFFFF_FF8E};
    exp_q.push_back(32'habcd1234); exp_q.push_back(32'h0000_00FF); exp_q.push_back(32'h0000_0007);
    exp_q.push_back(32'h55aa00ff); exp_q.push_back(32'h0);         exp_q.push_back(32'h0);
    exp_q.push_back(32'h0000_FF0E);
    for (int i = 0; i < 7; i++) begin
      apb_write(idx[i], wv[i]);
      apb_read(idx[i], d);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== e) begin n_fail++; $display("FAIL regs_idx%0d: got %h expected %h", idx[i], d, e); end
    end
    n_checks++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL ctrl_no_start: cs_n got %b expected 1", cs_n); end
    apb_write(4'd5, 32'h0000_0100);
  endtask

  task automatic test_cmd_only();
    bit ok; int m; logic [31:0] d;
    apb_write(4'd0, 32'h9F); apb_write(4'd2, 32'h0);
    prep_txn(); push_bits(32'h9F, 8);
    apb_write(4'd5, 32'h0000_0001);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL cmd_timeout: done %b expected 1", ok); end
    n_checks++; if (pulses != 8) begin n_fail++; $display("FAIL cmd_pulses: got %0d expected 8", pulses); end
    n_checks++; if (cs_cnt != 17) begin n_fail++; $display("FAIL cmd_cs_low: got %0d expected 17", cs_cnt); end
    m = drain_mismatches();
    n_checks++; if (m != 0) begin n_fail++; $display("FAIL cmd_bits: got %0d mismatches expected 0", m); end
    exp_q.push_back(32'h0);
    apb_read(4'd5, d);
    n_checks++; if (d !== exp_q[0]) begin n_fail++; $display("FAIL cmd_ctrl_idle: got %h expected %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_read_24();
    bit ok; int m; logic [31:0] d;
    apb_write(4'd0, 32'h03); apb_write(4'd1, 32'h0012_3456); apb_write(4'd2, 32'h2);
    slave_bits = {32'h0, 16'hA53C, 24'h0};
    prep_txn(); push_bits(32'h03, 8); push_bits(32'h123456, 24); push_bits(32'h0, 16);
    exp_q.push_back(32'h0000_A53C); exp_q.push_back(32'h0000_0006);
    apb_write(4'd5, 32'h0000_0007);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rd_timeout: done %b expected 1", ok); end
    n_checks++; if (pulses != 48) begin n_fail++; $display("FAIL rd_pulses: got %0d expected 48", pulses); end
    n_checks++; if (cs_cnt != 97) begin n_fail++; $display("FAIL rd_cs_low: got %0d expected 97", cs_cnt); end
    m = drain_mismatches();
    n_checks++; if (m != 0) begin n_fail++; $display("FAIL rd_bits: got %0d mismatches expected 0", m); end
    apb_read(4'd4, d);
    n_checks++; if (d !== exp_q[0]) begin n_fail++; $display("FAIL rd_rdata: got %h expected %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
    apb_read(4'd5, d);
    n_checks++; if (d !== exp_q[0]) begin n_fail++; $display("FAIL rd_ctrl: got %h expected %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_busy_ignore();
    bit ok; int m; logic [31:0] d, e;
    apb_write(4'd0, 32'h02); apb_write(4'd1, 32'hCAFE_F00D);
    apb_write(4'd2, 32'h7);  apb_write(4'd3, 32'h1122_3344);
    slave_bits = {72{1'b1}};
    prep_txn(); push_bits(32'h02, 8); push_bits(32'hCAFE_F00D, 32); push_bits(32'h1122_3344, 32);
    apb_write(4'd5, 32'h0000_010D);
    exp_q.push_back(32'h0000_018C);
    apb_read(4'd5, d);
    e = exp_q.pop_front();
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL busy_ctrl: got %h expected %h", d, e); end
    apb_write(4'd3, 32'hDEAD_BEEF); apb_write(4'd5, 32'h0000_0001);
    apb_write(4'd2, 32'h1);         apb_write(4'd0, 32'hFF);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL busy_timeout: done %b expected 1", ok); end
    n_checks++; if (pulses != 72) begin n_fail++; $display("FAIL busy_pulses: got %0d expected 72", pulses); end
    n_checks++; if (cs_cnt != 290) begin n_fail++; $display("FAIL busy_cs_low: got %0d expected 290", cs_cnt); end
    m = drain_mismatches();
    n_checks++; if (m != 0) begin n_fail++; $display("FAIL busy_bits: got %0d mismatches expected 0", m); end
    exp_q.push_back(32'h1122_3344); exp_q.push_back(32'h7);
    exp_q.push_back(32'h0000_010C); exp_q.push_back(32'h0000_A53C); exp_q.push_back(32'h02);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] a;
      a = (i == 0) ? 4'd3 : (i == 1) ? 4'd2 : (i == 2) ? 4'd5 : (i == 3) ? 4'd4 : 4'd0;
      apb_read(a, d);
      e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL busy_after_idx%0d: got %h expected %h", a, d, e); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int m;
    apb_write(4'd0, 32'hA5); apb_write(4'd2, 32'h1); apb_write(4'd3, 32'h3C);
    prep_txn(); push_bits(32'hA5, 8); push_bits(32'h3C, 8);
    apb_write(4'd5, 32'h0000_0001);
    wait_done(ok);
    n_checks++; if (cs_cnt != 33 || !ok) begin n_fail++; $display("FAIL b2b_first_cs: got %0d expected 33", cs_cnt); end
    m = drain_mismatches();
    n_checks++; if (m != 0) begin n_fail++; $display("FAIL b2b_first_bits: got %0d mismatches expected 0", m); end
    apb_write(4'd0, 32'h0F);
    prep_txn(); push_bits(32'h0F, 8); push_bits(32'h3C, 8);
    apb_write(4'd5, 32'h0000_0101);
    wait_done(ok);
    n_checks++; if (cs_cnt != 66 || !ok) begin n_fail++; $display("FAIL b2b_second_cs: got %0d expected 66", cs_cnt); end
    m = drain_mismatches();
    n_checks++; if (m != 0) begin n_fail++; $display("FAIL b2b_second_bits: got %0d mismatches expected 0", m); end
  endtask

  task automatic test_reset_midtransfer();
    logic [31:0] d, e;
    apb_write(4'd0, 32'h5A); apb_write(4'd2, 32'h4); apb_write(4'd3, 32'hFFFF_FFFF);
    apb_write(4'd5, 32'h0000_0301);
    repeat (20) @(posedge pclk);
    #1;
    n_checks++; if (cs_n !== 1'b0) begin n_fail++; $display("FAIL mid_active: cs_n got %b expected 0", cs_n); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_cs: got %b expected 1", cs_n); end
    n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sclk: got %b expected 0", sclk); end
    n_checks++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sdo: got %b expected 0", sdo); end
    @(negedge pclk); rst_n = 1'b1;
    exp_q.push_back(32'h0000_0100); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);         exp_q.push_back(32'h0);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] a;
      a = (i == 0) ? 4'd5 : (i == 1) ? 4'd0 : (i == 2) ? 4'd2 : (i == 3) ? 4'd3 : 4'd4;
      apb_read(a, d);
      e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL mid_rst_idx%0d: got %h expected %h", a, d, e); end
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_cmd_only();
    test_read_24();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midtransfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_spi_master_ctrl.md
Name: apb_spi_master_ctrl

Overview:
- APB3 slave that owns a small register file and runs single-chip-select SPI master transactions: command byte, optional address, then 0-4 data bytes written or read.
- Sits behind the AHB-to-APB bridge on a 4-bit word-index APB address space.
- Drives the external SPI pins directly.

Parameters:
- ADDR_WIDTH, 4, width of paddr_i; it is a word index, not a byte address.
- DEFAULT_DIV, 1, reset value of CTRL.clkdiv.

Ports:
- pclk_i  in  1  system clock; all logic is on its rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- psel_i  in  1  APB select.
- penable_i  in  1  APB access phase.
- paddr_i  in  ADDR_WIDTH  register index.
- pwrite_i  in  1  1 = write.
- pwdata_i  in  32  write data.
- prdata_o  out  32  read data.
- pready_o  out  1  APB ready.
- spi_clk_o  out  1  SPI clock, mode 0.
- spi_sdo_o  out  1  MOSI.
- spi_cs_n_o  out  1  active-low chip select.
- spi_sdi_i  in  1  MISO.

Behaviour:
- Register map (index : name):
  - 0 CMD: bits [7:0], RW.
  - 1 ADDR: bits [31:0], RW.
  - 2 LEN: bits [2:0], RW; values above 4 are treated as 4.
  - 3 WDATA: bits [31:0], RW.
  - 4 RDATA: bits [31:0], RO.
  - 5 CTRL: see fields below.
  - Other indices read 0; writes to them are ignored.
- CTRL fields:
  - [0] start: write 1 to launch; always reads 0.
  - [1] rw: 1 = read data phase.
  - [2] addr_en.
  - [3] addr32: 1 = 32 address bits, 0 = 24.
  - [7] busy: read-only.
  - [15:8] clkdiv.
  - All other bits read 0.
- Reset values: all registers 0 except clkdiv = DEFAULT_DIV. Outputs at reset: spi_clk_o 0, spi_cs_n_o 1, spi_sdo_o 0, pready_o 1, prdata_o 0.
- APB handshake:
  - pready_o is tied to 1, so there are zero wait states.
  - A write commits on the rising edge where psel_i, penable_i and pwrite_i are all 1.
  - prdata_o is combinational: it equals the indexed register while psel_i && !pwrite_i, otherwise 0.
- While busy:
  - Writes to CMD, ADDR, LEN, WDATA and CTRL are ignored.
  - Reads work normally.
- Start sequence:
  - A CTRL write with bit0=1 while idle latches rw, addr_en, addr32 and clkdiv.
  - In the following cycle busy=1 and spi_cs_n_o goes low.
- Shift order: bits are sent MSB first, in this order:
  1. CMD[7:0].
  2. If addr_en: ADDR[31:0] when addr32=1, otherwise ADDR[23:0].
  3. If LEN>0 and rw=0: WDATA[8*LEN-1:0].
  4. If LEN>0 and rw=1: 8*LEN clocks with spi_sdo_o = 0.
- Total bit count: N = 8 + (addr_en ? (addr32 ? 32 : 24) : 0) + 8*LEN.
- SPI timing, with half-period H = clkdiv+1 pclk cycles:
  - Each bit's value is on spi_sdo_o when CS falls or at the preceding spi_clk_o falling edge.
  - spi_clk_o rises after H cycles and falls after another H cycles.
  - There are N rising edges.
  - After the last falling edge the block waits H more cycles, then spi_cs_n_o rises and busy clears in the same cycle.
  - spi_cs_n_o stays low for exactly (2N+1)*H cycles.
- Read phase:
  - RDATA is cleared to 0 at start.
  - spi_sdi_i is sampled on each spi_clk_o rising edge of the data phase and shifted in at the LSB.
  - Result: RDATA[8*LEN-1:0] holds the received bytes, first byte most significant.
- Write transactions (rw=0) leave RDATA unchanged.
- Asynchronous reset at any time aborts the transaction immediately and restores all reset values.
- A CTRL write with start=0 while idle only updates the fields.

Test Plan:
- Reset then read all indices -> ADDR, CMD, WDATA, LEN, RDATA = 0; CTRL = 0x00000100 (clkdiv 1, busy 0).
- Write ADDR=0xabcd1234, read ADDR -> 0xabcd1234; write CMD=0x1FF, read -> 0x000000FF.
- CMD=0x9F, LEN=0, CTRL=0x00000001 with clkdiv 0 -> 8 spi_clk pulses, sdo 1,0,0,1,1,1,1,1, CS low for 17 cycles, busy then clears.
- CMD=0x03, ADDR=0x00123456, LEN=2, CTRL=0x07 (read, 24-bit addr), slave returns 0xA5,0x3C -> 48 clocks, RDATA=0x0000A53C.
- Mid-transaction write to WDATA and a second start -> both ignored, transaction completes unchanged; LEN=7 behaves as LEN=4.
- Assert rst_n_i mid-transfer -> spi_cs_n_o=1 and spi_clk_o=0 immediately, busy=0, registers reset.
